// File: rtl/gpio_port_responder_if.sv
// Decoder-to-GPIO bus: select, address, load/store strobes, store data and load data.
interface gpio_port_responder_if;
  localparam int unsigned BUS_W = 32;

  logic             sel_in;
  logic [BUS_W-1:0] Adr_in;
  logic             MemWrite_in;
  logic             MemRead_in;
  logic [BUS_W-1:0] Data_in;
  logic [BUS_W-1:0] Data_out;

  modport master (output sel_in, Adr_in, MemWrite_in, MemRead_in, Data_in, input Data_out);
  modport slave  (input sel_in, Adr_in, MemWrite_in, MemRead_in, Data_in, output Data_out);
endinterface

// File: rtl/gpio_port_responder.sv
// GPIO responder: OUT register at 0x0024, synchronized IN / W1C rising-edge flags at 0x0028, irq.
// Optional input debounce when GPIO_DEBOUNCE_EN is defined.
module gpio_port_responder #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_port_responder_if.slave  bus,
  input  logic [WIDTH-1:0]      gpio_in,
  output logic [WIDTH-1:0]      gpio_out,
  output logic                  irq
);
  localparam logic [15:0] OFS_OUT = 16'h0024;
  localparam logic [15:0] OFS_IN  = 16'h0028;

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("gpio_port_responder: WIDTH must be 1..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("gpio_port_responder: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync1, sync2, in_q, prev, edge_q;
  logic [WIDTH-1:0] rise, clr, edge_next;
  logic             acc_out, acc_in;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign acc_out = bus.sel_in && (bus.Adr_in[15:0] == OFS_OUT);
  assign acc_in  = bus.sel_in && (bus.Adr_in[15:0] == OFS_IN);

  // A new rising edge in the same cycle as its clear keeps the flag set.
  assign clr       = (bus.MemWrite_in && acc_in) ? bus.Data_in[16 +: WIDTH] : '0;
  assign rise      = in_q & ~prev;
  assign edge_next = (edge_q & ~clr) | rise;

  // Zero-latency load path; idle bus reads as zero.
  always_comb begin
    rdata = '0;
    if (bus.MemRead_in) begin
      if (acc_out)     rdata = 32'(gpio_out);
      else if (acc_in) rdata = {16'(edge_q), 16'(in_q)};
    end
  end
  assign bus.Data_out = rdata;

  assign unused_bits = ^{bus.Adr_in[31:16], bus.Data_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      edge_q   <= '0;
      irq      <= 1'b0;
    end else begin
      sync1  <= gpio_in;
      sync2  <= sync1;
      prev   <= in_q;
      edge_q <= edge_next;
      irq    <= |edge_next;
      if (bus.MemWrite_in && acc_out) gpio_out <= bus.Data_in[WIDTH-1:0];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // Each bit follows sync2 only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] != in_q[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            in_q[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign in_q = sync2;
`endif

endmodule

// File: tb/tb_gpio_port_responder.sv
// Randomized bench for gpio_port_responder with a behavioural model and directed literal checks.
module tb_gpio_port_responder;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 3 + int'(D);
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic         irq;

  always #5 clk = ~clk;

  gpio_port_responder_if bus ();

  gpio_port_responder #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  // Model state: register contents and the pin values sampled one and two edges ago.
  logic [W-1:0] m_out, m_edge, m_prev, m_filt, pin1, pin2;
  bit           m_irq;
  int           run [W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Input level as seen by the edge detector right now.
  function automatic logic [W-1:0] cur_inq();
`ifdef GPIO_DEBOUNCE_EN
    return m_filt;
`else
    return pin2;
`endif
  endfunction

  function automatic logic [31:0] model_read();
    if (!bus.MemRead_in || !bus.sel_in) return 32'h0;
    if (bus.Adr_in[15:0] == 16'h0024) return 32'(m_out);
    if (bus.Adr_in[15:0] == 16'h0028) return {16'(m_edge), 16'(cur_inq())};
    return 32'h0;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input logic [W-1:0] pins);
    logic [W-1:0] inq_b, rise, clr;
    if (r) begin
      m_out = '0; m_edge = '0; m_prev = '0; m_filt = '0; pin1 = '0; pin2 = '0; m_irq = 0;
      for (int i = 0; i < int'(W); i++) run[i] = 0;
      return;
    end
    inq_b  = cur_inq();
    rise   = inq_b & ~m_prev;
    m_prev = inq_b;
    clr    = (s && we && a[15:0] == 16'h0028) ? d[16 +: W] : '0;
    m_edge = (m_edge & ~clr) | rise;
    m_irq  = |m_edge;
    if (s && we && a[15:0] == 16'h0024) m_out = d[W-1:0];
`ifdef GPIO_DEBOUNCE_EN
    for (int i = 0; i < int'(W); i++) begin
      if (pin2[i] != m_filt[i]) begin
        run[i]++;
        if (run[i] == int'(D)) begin
          m_filt[i] = pin2[i];
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
`endif
    pin2 = pin1;
    pin1 = pins;
  endtask

  task automatic drive(input bit s, input logic [15:0] ofs, input bit we, input bit re,
                       input logic [31:0] d);
    bus.sel_in      = s;
    bus.Adr_in      = {16'($urandom), ofs};
    bus.MemWrite_in = we;
    bus.MemRead_in  = re;
    bus.Data_in     = d;
  endtask

  task automatic tick();
    bit r, s, we;
    logic [31:0] a, d;
    logic [W-1:0] p;
    r = reset; s = bus.sel_in; we = bus.MemWrite_in; a = bus.Adr_in; d = bus.Data_in; p = gpio_in;
    @(posedge clk);
    model_edge(r, s, we, a, d, p);
    armed = 1'b1;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Read data after a short settle, compared against a literal.
  task automatic read_chk(input string name, input logic [15:0] ofs, input logic [31:0] exp);
    drive(1, ofs, 0, 1, 32'h0);
    #1;
    chk(name, bus.Data_out, exp);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("gpio_out", 32'(gpio_out), 32'(m_out));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("Data_out", bus.Data_out, model_read());
    end
  end

  initial begin
    reset   = 1'b1;
    gpio_in = '0;
    drive(0, 16'h0, 0, 0, 32'h0);
    ticks(2);
    reset = 1'b0;
    chk("reset gpio_out", 32'(gpio_out), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    read_chk("reset read IN", 16'h0028, 32'h0000_0000);

    drive(1, 16'h0024, 1, 0, 32'hFFFF_FFA5);
    tick();
    chk("out write", 32'(gpio_out), 32'h0000_00A5);
    read_chk("out read", 16'h0024, 32'h0000_00A5);
    drive(1, 16'h0024, 0, 0, 32'h0);
    #1;
    chk("no read zero", bus.Data_out, 32'h0);
    read_chk("bad offset read", 16'h0020, 32'h0);

    // Rising pins reach the edge flags LAT edges after they are first sampled.
    drive(0, 16'h0, 0, 0, 32'h0);
    gpio_in = 8'h03;
    ticks(LAT - 1);
    chk("irq before latency", 32'(irq), 32'h0);
    tick();
    chk("irq at latency", 32'(irq), 32'h1);
    read_chk("in/edge read", 16'h0028, 32'h0003_0003);

    drive(1, 16'h0028, 1, 0, 32'h0001_FFFF);
    tick();
    chk("w1c bit0 irq", 32'(irq), 32'h1);
    read_chk("w1c bit0 read", 16'h0028, 32'h0002_0003);
    drive(1, 16'h0028, 1, 0, 32'h0002_0000);
    tick();
    chk("w1c last irq", 32'(irq), 32'h0);

    // Read and write in the same cycle returns the old value.
    drive(1, 16'h0024, 1, 1, 32'h0000_003C);
    #1;
    chk("rw pre-write read", bus.Data_out, 32'h0000_00A5);
    tick();
    chk("rw write commits", 32'(gpio_out), 32'h0000_003C);

    // Set wins over clear in the same cycle.
    drive(0, 16'h0, 0, 0, 32'h0);
    gpio_in = 8'h00;
    ticks(LAT + 1);
    gpio_in = 8'h01;
    ticks(LAT - 1);
    drive(1, 16'h0028, 1, 0, 32'h0001_0000);
    tick();
    chk("set wins irq", 32'(irq), 32'h1);
    read_chk("set wins read", 16'h0028, 32'h0001_0001);

    drive(0, 16'h0024, 1, 0, 32'h0000_005A);
    tick();
    chk("unselected write", 32'(gpio_out), 32'h0000_003C);

    // Reset clears pending flags and discards a simultaneous store.
    reset = 1'b1;
    drive(1, 16'h0024, 1, 0, 32'h0000_0077);
    tick();
    reset = 1'b0;
    chk("mid reset gpio_out", 32'(gpio_out), 32'h0);
    chk("mid reset irq", 32'(irq), 32'h0);
    read_chk("mid reset read", 16'h0028, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    drive(0, 16'h0, 0, 0, 32'h0);
    gpio_in = 8'h00;
    ticks(LAT + 1);
    gpio_in = 8'h01;
    ticks(3);
    gpio_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch irq", 32'(irq), 32'h0);
    end
    gpio_in = 8'h01;
    ticks(LAT - 1);
    chk("debounce irq early", 32'(irq), 32'h0);
    tick();
    chk("debounce irq", 32'(irq), 32'h1);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ofs;
      case ($urandom_range(0, 4))
        0, 1:    ofs = 16'h0024;
        2, 3:    ofs = 16'h0028;
        default: ofs = 16'($urandom);
      endcase
      drive($urandom_range(0, 7) != 0, ofs, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 32'h0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
